chan_mux_seq: RTL and testbench
===============================

# chan_mux_seq

Parametrised N-channel, W-bit registered multiplexer for DE2 switch/LED datapaths, generalising the lab 2-to-1 select to arbitrary width and channel count. Adds an auto-scan mode that rotates through channels on a programmable dwell period, plus a hold freeze. Sits between switch/register sources and LED or 7-segment display drivers, and exposes the active channel index for display.

## Interface
- `W`, 8: data width per channel.
- `N`, 4: channel count, ≥2.
- `DIV`, 50_000_000: dwell period in clk cycles per channel in auto mode, ≥1.
- `clk`  in  1: system clock (CLOCK_50 domain).
- `reset`  in  1: asynchronous, active-high reset.
- `data_in`  in  N*W: channel c occupies bits [c*W +: W].
- `sel`  in  SELW: manual channel select; SELW = max(1, clog2(N)).
- `auto_en`  in  1: 1 = auto-scan, 0 = manual.
- `hold`  in  1: freeze all state and outputs.
- `data_out`  out  W: registered selected data.
- `chan_out`  out  SELW: channel index currently driving data_out.
- `chg`  out  1: one-cycle pulse when chan_out changes value.

## Operation
- State: channel index `idx`, dwell counter `cnt` (0..DIV-1), mode register.
- Reset: idx=0, cnt=0, data_out=0, chan_out=0, chg=0, mode=MANUAL.
- Priority each cycle: hold > mode update > index update.
- hold=1: idx, cnt, data_out, chan_out frozen; chg=0. data_out does not track data_in changes.
- MANUAL (auto_en=0): if sel<N, idx←sel; if sel≥N, idx unchanged. cnt held at 0.
- AUTO (auto_en=1): cnt increments; at cnt=DIV-1, cnt←0 and idx←(idx==N-1 ? 0 : idx+1).
- MANUAL→AUTO: cnt restarts from 0; scan continues from current idx.
- AUTO→MANUAL: takes effect the same cycle auto_en is sampled low; pending expiry discarded.
- data_out ← data_in[idx_next] every non-hold cycle (live tracking of selected channel); chan_out ← idx_next.
- chg=1 in the cycle after idx changes, aligned with new chan_out/data_out.
- Counter width clog2(DIV)+1; no overflow, compare is exact equality.

## Timing
- Latency: sel or data_in change → data_out/chan_out updated 1 clk later.
- Auto dwell: each channel presented exactly DIV cycles (absent hold).
- Expiry coincident with hold=1: hold wins; cnt stays at DIV-1; advance occurs on first cycle after hold drops.
- Expiry coincident with auto_en falling: manual wins; idx←sel.
- Reset asserted mid-dwell: all registers return to reset values immediately (async); resume on first clk edge after deassertion.
- DIV=1: idx advances every cycle in auto mode.

## Configuration
- `CHAN_MUX_SKIP_EN` defined: adds input `chan_mask` [N-1:0]; auto-scan advances to the next channel (wrapping) with mask bit 1, searching at most N-1 positions; if no other channel is enabled, idx unchanged. Manual mode ignores the mask.
- Not defined: no `chan_mask` port; auto-scan visits all N channels in order.

## Structure
- Package `chan_mux_pkg`: mode enum {MODE_MANUAL, MODE_AUTO}, `sel_width(N)` function, reset-value constants.
- One sub-module: `dwell_counter` (parameter DIV; inputs clk, reset, run, clr; output `tick` at DIV-1).
- Next-index logic (wrap, mask search) stays in the top module as combinational function.

## Test plan
- W=8,N=4,DIV=3; reset, data_in={8'h44,8'h33,8'h22,8'h11} → data_out=8'h00, chan_out=0, chg=0; after first clk with sel=0, data_out=8'h11.
- Manual sel=2 → one clk later data_out=8'h33, chan_out=2, chg pulses once; N=3 with sel=3 → chan_out unchanged, no chg.
- auto_en=1 from idx=0 → chan_out 0,0,0,1,1,1,2,2,2,3,3,3,0 over 13 cycles; chg on each transition, including 3→0 wrap.
- hold=1 in cycle of expiry at idx=1 for 5 cycles, data_in changed meanwhile → data_out/chan_out frozen; idx=2 one cycle after hold drops.
- Reset pulsed at cnt=1, idx=2 in auto → immediate data_out=0, chan_out=0; dwell restarts from 0.
- With CHAN_MUX_SKIP_EN, chan_mask=4'b1010, auto → chan_out sequence 1,3,1,3 each DIV cycles; chan_mask=4'b0010 at idx=1 → stays 1, no chg.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared types and constants for the channel multiplexer.
// Mode enum, select-width helper and reset values.
package chan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    localparam mode_e RST_MODE = MODE_MANUAL;
    localparam int    RST_IDX  = 0;
    localparam logic  RST_CHG  = 1'b0;

    // Width of a channel index; never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts run cycles 0..DIV-1 and flags the last one.
// clr restarts the count from 0 in the same cycle it is asserted.
module dwell_counter #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] base;

    // Effective count this cycle, expiry flag and next count.
    always_comb begin
        base  = clr ? '0 : cnt_q;
        tick  = run && (base == LAST);
        cnt_d = base;
        if (run) begin
            cnt_d = tick ? '0 : base + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: N-channel registered mux with manual select, auto-scan, hold.
// Define CHAN_MUX_SKIP_EN to add chan_mask so auto-scan skips masked channels.
module chan_mux_seq
    import chan_mux_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 4,
    parameter  int DIV  = 50_000_000,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  data_in,
    input  logic [SELW-1:0] sel,
    input  logic            auto_en,
    input  logic            hold,
`ifdef CHAN_MUX_SKIP_EN
    input  logic [N-1:0]    chan_mask,
`endif
    output logic [W-1:0]    data_out,
    output logic [SELW-1:0] chan_out,
    output logic            chg
);

`ifdef CHAN_MUX_SKIP_EN
    // Nearest enabled channel after cur (wrapping); cur if none.
    function automatic logic [SELW-1:0] next_idx(
        input logic [SELW-1:0] cur,
        input logic [N-1:0]    mask
    );
        int c;
        next_idx = cur;
        for (int k = N - 1; k >= 1; k--) begin
            c = (int'(cur) + k) % N;
            if (mask[c]) begin
                next_idx = SELW'(c);
            end
        end
    endfunction
`else
    // Next channel in order, wrapping N-1 -> 0.
    function automatic logic [SELW-1:0] next_idx(
        input logic [SELW-1:0] cur
    );
        return (int'(cur) == N - 1) ? '0 : cur + 1'b1;
    endfunction
`endif

    mode_e           mode_q;
    mode_e           mode_d;
    logic [SELW-1:0] idx_q;
    logic [SELW-1:0] idx_d;
    logic [W-1:0]    data_q;
    logic [W-1:0]    data_d;
    logic            chg_q;
    logic            chg_d;
    logic            run;
    logic            clr;
    logic            tick;

    // Mode follows auto_en unless frozen; counter restarts on any mode change.
    always_comb begin
        mode_d = hold ? mode_q : (auto_en ? MODE_AUTO : MODE_MANUAL);
        run    = !hold && (mode_d == MODE_AUTO);
        clr    = !hold && ((mode_d == MODE_MANUAL) || (mode_q != mode_d));
    end

    dwell_counter #(
        .DIV (DIV)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (clr),
        .tick  (tick)
    );

    // Next index, selected data and change flag.
    always_comb begin
        idx_d = idx_q;
        if (!hold) begin
            if (!auto_en) begin
                if (int'(sel) < N) begin
                    idx_d = sel;
                end
            end else if (tick) begin
`ifdef CHAN_MUX_SKIP_EN
                idx_d = next_idx(idx_q, chan_mask);
`else
                idx_d = next_idx(idx_q);
`endif
            end
        end
        data_d = hold ? data_q : data_in[int'(idx_d)*W +: W];
        chg_d  = !hold && (idx_d != idx_q);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= RST_MODE;
            idx_q  <= SELW'(RST_IDX);
            data_q <= '0;
            chg_q  <= RST_CHG;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            chg_q  <= chg_d;
        end
    end

    assign data_out = data_q;
    assign chan_out = idx_q;
    assign chg      = chg_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// tb_chan_mux_seq: directed checks of manual select, auto-scan, hold, reset.
// Mask-skip steps run only when CHAN_MUX_SKIP_EN is defined.
module tb_chan_mux_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        auto_en;
    logic        hold;
    logic [7:0]  dout;
    logic [1:0]  chan;
    logic        chg;

    logic [23:0] din3;
    logic [1:0]  sel3;
    logic [7:0]  dout3;
    logic [1:0]  chan3;
    logic        chg3;

`ifdef CHAN_MUX_SKIP_EN
    logic [3:0]  mask;
    logic [2:0]  mask3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chan_mux_seq #(.W(8), .N(4), .DIV(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (din),
        .sel       (sel),
        .auto_en   (auto_en),
        .hold      (hold),
`ifdef CHAN_MUX_SKIP_EN
        .chan_mask (mask),
`endif
        .data_out  (dout),
        .chan_out  (chan),
        .chg       (chg)
    );

    chan_mux_seq #(.W(8), .N(3), .DIV(3)) u_n3 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (din3),
        .sel       (sel3),
        .auto_en   (1'b0),
        .hold      (1'b0),
`ifdef CHAN_MUX_SKIP_EN
        .chan_mask (mask3),
`endif
        .data_out  (dout3),
        .chan_out  (chan3),
        .chg       (chg3)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int ec, input int ed,
                       input int eg);
        check({tag, ".chan"}, 32'(chan), 32'(ec));
        check({tag, ".data"}, 32'(dout), 32'(ed));
        check({tag, ".chg"},  32'(chg),  32'(eg));
    endtask

    initial begin
        int c;
        reset   = 1'b1;
        din     = 32'h4433_2211;
        sel     = 2'd0;
        auto_en = 1'b0;
        hold    = 1'b0;
        din3    = 24'h33_2211;
        sel3    = 2'd1;
`ifdef CHAN_MUX_SKIP_EN
        mask    = 4'hF;
        mask3   = 3'h7;
`endif
        @(posedge clk);
        #2;
        chk("rst", 0, 8'h00, 0);
        check("rst.chan3", 32'(chan3), 0);
        @(negedge clk);
        reset = 1'b0;

        step;
        chk("first", 0, 8'h11, 0);
        check("first.chan3", 32'(chan3), 1);
        check("first.data3", 32'(dout3), 8'h22);
        check("first.chg3", 32'(chg3), 1);

        sel  = 2'd2;
        sel3 = 2'd3;
        step;
        chk("sel2", 2, 8'h33, 1);
        check("badsel.chan3", 32'(chan3), 1);
        check("badsel.chg3", 32'(chg3), 0);
        check("badsel.data3", 32'(dout3), 8'h22);

        din[23:16] = 8'h5A;
        step;
        chk("live", 2, 8'h5A, 0);

        din = 32'h4433_2211;
        sel = 2'd0;
        step;
        chk("sel0", 0, 8'h11, 1);
        step;
        chk("sel0b", 0, 8'h11, 0);

        auto_en = 1'b1;
        chk("auto0", 0, 8'h11, 0);
        for (int k = 1; k <= 17; k++) begin
            step;
            c = (k / 3) % 4;
            chk($sformatf("auto%0d", k), c, 17 * (c + 1),
                (k % 3 == 0) ? 1 : 0);
        end

        hold      = 1'b1;
        din[15:8] = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            step;
            chk($sformatf("hold%0d", k), 1, 8'h22, 0);
        end
        hold = 1'b0;
        din  = 32'h4433_2211;
        step;
        chk("unhold", 2, 8'h33, 1);
        step;
        chk("pre_rst", 2, 8'h33, 0);

        reset = 1'b1;
        #1;
        chk("async_rst", 0, 8'h00, 0);
        #1;
        reset = 1'b0;
        step;
        chk("rs1", 0, 8'h11, 0);
        step;
        chk("rs2", 0, 8'h11, 0);
        step;
        chk("rs3", 1, 8'h22, 1);
        step;
        chk("a1", 1, 8'h22, 0);
        step;
        chk("a2", 1, 8'h22, 0);

        auto_en = 1'b0;
        sel     = 2'd3;
        step;
        chk("exit", 3, 8'h44, 1);
        check("exit.chan3", 32'(chan3), 0);
        check("exit.chg3", 32'(chg3), 0);

        hold = 1'b1;
        sel  = 2'd1;
        step;
        chk("mhold", 3, 8'h44, 0);
        hold = 1'b0;
        step;
        chk("mrel", 1, 8'h22, 1);

`ifdef CHAN_MUX_SKIP_EN
        mask    = 4'b1010;
        auto_en = 1'b1;
        step;
        step;
        step;
        chk("skip3", 3, 8'h44, 1);
        step;
        step;
        step;
        chk("skip1", 1, 8'h22, 1);
        mask = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step;
            chk($sformatf("solo%0d", k), 1, 8'h22, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
